mont_domain_conv: RTL and testbench
===================================

MONT_DOMAIN_CONV -- requirements
Module: mont_domain_conv

Interface
REQ-001 Parameter k, default 8: operand and modulus width in bits; R = 2^k.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request a conversion; sampled only in IDLE.
REQ-005 mode  input  1  0 = into Montgomery form (a*R mod n); 1 = out of Montgomery form (a*R^-1 mod n).
REQ-006 a  input  k  operand; must satisfy a < n.
REQ-007 n  input  k  modulus; must be odd and greater than 1.
REQ-008 result  output  k  converted value; valid from the done pulse onward.
REQ-009 busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive of the done cycle.
REQ-010 done  output  1  single-cycle pulse marking result valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and FINAL.
REQ-012 In IDLE, start=1 SHALL latch a, n and mode into internal registers, clear the iteration counter and move to RUN.
REQ-013 In RUN, mode 0 SHALL perform one step per cycle, using a (k+1)-bit accumulator: r <- 2r; if r >= n then r <- r - n.
REQ-014 In RUN, mode 1 SHALL perform one step per cycle, using a (k+1)-bit accumulator: if t[0] then t <- (t + n) >> 1, else t <- t >> 1.
REQ-015 RUN SHALL last exactly k cycles, counted by a counter of width clog2(k+1), and then move to FINAL.
REQ-016 FINAL SHALL apply one conditional subtraction (if acc >= n then acc <- acc - n).
REQ-017 FINAL SHALL write the low k bits of the accumulator to result, assert done for that one cycle and return to IDLE.
REQ-018 Latency SHALL be fixed: done is asserted k+1 cycles after the cycle in which start was sampled. Data-dependent timing is not allowed.
REQ-019 start asserted while in RUN or FINAL SHALL be ignored. Latched operands SHALL NOT change mid-operation.
REQ-020 Changes on a, n or mode after acceptance SHALL NOT affect the running conversion.
REQ-021 result SHALL hold its last value until the next FINAL cycle.
REQ-022 start asserted in the same cycle that FINAL returns to IDLE SHALL NOT be accepted; a new start is accepted from the following IDLE cycle.
REQ-023 Intermediate sums (2r, t+n) SHALL be computed at k+1 bits so no carry is lost when n has its MSB set.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, counter=0, accumulator=0, result=0, busy=0 and done=0.
REQ-025 Reset asserted during RUN or FINAL SHALL abort the conversion with no done pulse. result SHALL read 0 afterwards.

Configuration
REQ-026 Macro MONT_DOMAIN_CONV_CHECK_EN SHALL compile in operand checking.
REQ-027 With MONT_DOMAIN_CONV_CHECK_EN defined, a 1-bit output err SHALL exist, with reset value 0.
REQ-028 With the macro defined, a start with even n, n <= 1, or a >= n SHALL skip RUN and go directly to a single-cycle error completion: done=1 and err=1 on the next cycle, result unchanged.
REQ-029 With the macro defined, err SHALL be cleared on the next accepted start.
REQ-030 Without the macro, no err port or check logic SHALL exist, and result for illegal operands is unspecified.

Verification
REQ-031 k=8, n=13, mode=0, a=5, start -> done exactly 9 cycles later, result=6.
REQ-032 k=8, n=13, mode=1, a=6 -> result=5. Also sweep all a in 0..12 through mode 0 then mode 1 -> original a recovered each time.
REQ-033 k=8, n=255, mode=0, a=254 -> result=254. Then mode=1, a=1 -> result=1 (R^-1 = 1 mod 255), confirming no carry loss at the MSB.
REQ-034 Start a conversion, re-pulse start with different a at cycle 3 of RUN -> second start ignored, first result correct, single done pulse.
REQ-035 Assert rst_n=0 at cycle 4 of RUN -> next cycle IDLE, busy=0, result=0, no done; a fresh start then completes normally.
REQ-036 Macro defined: n=12, a=5, start -> done and err next cycle, result unchanged. A following legal start clears err.

Source files
------------

// File: rtl/mont_domain_conv_if.sv
// Handshake/operand bundle for mont_domain_conv.
// MONT_DOMAIN_CONV_CHECK_EN adds the err completion flag.
interface mont_domain_conv_if #(
  parameter int k = 8
);
  logic         start;
  logic         mode;
  logic [k-1:0] a;
  logic [k-1:0] n;
  logic [k-1:0] result;
  logic         busy;
  logic         done;
`ifdef MONT_DOMAIN_CONV_CHECK_EN
  logic         err;

  modport master (output start, mode, a, n, input result, busy, done, err);
  modport slave  (input start, mode, a, n, output result, busy, done, err);
`else
  modport master (output start, mode, a, n, input result, busy, done);
  modport slave  (input start, mode, a, n, output result, busy, done);
`endif
endinterface

// File: rtl/mont_domain_conv.sv
// Bit-serial conversion into (a*R mod n) or out of (a*R^-1 mod n) Montgomery form, R = 2^k.
// Define MONT_DOMAIN_CONV_CHECK_EN to reject even n, n <= 1 or a >= n with err.
module mont_domain_conv #(
  parameter int k = 8
) (
  input logic             clk,
  input logic             rst_n,
  mont_domain_conv_if.slave bus
);
  localparam int CW = $clog2(k + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [k:0]    acc;
  logic [k:0]    dbl;
  logic [k:0]    sum;
  logic [k:0]    step_val;
  logic [k:0]    final_val;
  logic [k-1:0]  n_q;
  logic [k-1:0]  result_q;
  logic          mode_q;
  logic          bad_req;
  logic          write_ok;

`ifdef MONT_DOMAIN_CONV_CHECK_EN
  logic err_q;

  always_comb begin
    bad_req = ~bus.n[0] || (bus.n <= k'(1)) || (bus.a >= bus.n);
  end

  // An error completion passes through FINAL without touching result.
  assign write_ok = ~err_q;
  assign bus.err  = err_q;
`else
  assign bad_req  = 1'b0;
  assign write_ok = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = bad_req ? FINAL : RUN;
      RUN:     if (cnt == CW'(k - 1)) state_nx = FINAL;
      FINAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc < n always holds, so 2r and t+n fit in k+1 bits without carry loss.
  always_comb begin
    dbl = acc << 1;
    sum = acc + {1'b0, n_q};
    if (!mode_q) begin
      step_val = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
    end else begin
      step_val = acc[0] ? (sum >> 1) : (acc >> 1);
    end
    final_val = (acc >= {1'b0, n_q}) ? acc - {1'b0, n_q} : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      n_q      <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
`ifdef MONT_DOMAIN_CONV_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= {1'b0, bus.a};
            n_q    <= bus.n;
            mode_q <= bus.mode;
            cnt    <= '0;
`ifdef MONT_DOMAIN_CONV_CHECK_EN
            err_q  <= bad_req;
`endif
          end
        end
        RUN: begin
          acc <= step_val;
          cnt <= cnt + CW'(1);
        end
        FINAL: begin
          if (write_ok) begin
            acc      <= final_val;
            result_q <= final_val[k-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // result is bypassed during FINAL so it is valid in the same cycle as done.
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == FINAL);
  assign bus.result = (state == FINAL && write_ok) ? final_val[k-1:0] : result_q;

endmodule

// File: tb/tb_mont_domain_conv.sv
// Self-checking bench for mont_domain_conv: directed cases plus randomized traffic
// against a cycle-level arithmetic reference model.
module tb_mont_domain_conv;
  localparam int K = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_en = 1'b0;

  mont_domain_conv_if #(.k(K)) bif ();

  mont_domain_conv #(.k(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Reference: a*R mod n, or the unique x < n with x*R mod n == a.
  function automatic int conv(input int va, input int vn, input bit vm);
    if (!vm) return (va << K) % vn;
    for (int x = 0; x < vn; x++) begin
      if (((x << K) % vn) == va) return x;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Model: phase counts cycles since acceptance; phase K+1 is the done cycle.
  int phase = 0;
  int m_exp = 0;
  int m_res = 0;
  bit m_err = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase = 0;
      m_res = 0;
      m_err = 1'b0;
    end else if (phase == 0) begin
      if (bif.start === 1'b1) begin
`ifdef MONT_DOMAIN_CONV_CHECK_EN
        if ((bif.n % 2 == 0) || (bif.n <= 1) || (bif.a >= bif.n)) begin
          phase = K + 1;
          m_exp = m_res;
          m_err = 1'b1;
        end else begin
          phase = 1;
          m_exp = conv(int'(bif.a), int'(bif.n), bif.mode);
          m_err = 1'b0;
        end
`else
        phase = 1;
        m_exp = conv(int'(bif.a), int'(bif.n), bif.mode);
`endif
      end
    end else if (phase == K + 1) begin
      phase = 0;
      m_res = m_exp;
    end else begin
      phase++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(bif.busy), 32'(phase != 0));
      check("cyc_done", 32'(bif.done), 32'(phase == K + 1));
      check("cyc_result", 32'(bif.result), (phase == K + 1) ? m_exp : m_res);
`ifdef MONT_DOMAIN_CONV_CHECK_EN
      check("cyc_err", 32'(bif.err), 32'(m_err));
`endif
    end
  end

  task automatic wait_done(output logic [7:0] r, output int lat);
    lat = 1;
    while (bif.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r = bif.result;
  endtask

  task automatic do_conv(input logic [7:0] ta, input logic [7:0] tn, input logic tm,
                         output logic [7:0] r, output int lat);
    @(negedge clk);
    bif.a = ta;
    bif.n = tn;
    bif.mode = tm;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    wait_done(r, lat);
  endtask

  logic [7:0] r;
  logic [7:0] m;
  int lat;
  int dones;

  initial begin
    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.mode = 1'b0;
    bif.a = '0;
    bif.n = 8'd3;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_done", 32'(bif.done), 0);
    check("rst_result", 32'(bif.result), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_conv(8'd5, 8'd13, 1'b0, r, lat);
    check("to_mont_5_13", 32'(r), 6);
    check("latency", 32'(lat), 9);
    do_conv(8'd6, 8'd13, 1'b1, r, lat);
    check("from_mont_6_13", 32'(r), 5);
    do_conv(8'd254, 8'd255, 1'b0, r, lat);
    check("to_mont_254_255", 32'(r), 254);
    do_conv(8'd1, 8'd255, 1'b1, r, lat);
    check("from_mont_1_255", 32'(r), 1);

    for (int i = 0; i < 13; i++) begin
      do_conv(8'(i), 8'd13, 1'b0, m, lat);
      do_conv(m, 8'd13, 1'b1, r, lat);
      check("roundtrip_13", 32'(r), 32'(i));
    end

    // Restart attempt mid-RUN must be ignored.
    @(negedge clk);
    bif.a = 8'd5; bif.n = 8'd13; bif.mode = 1'b0; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    dones = 0;
    for (int cyc = 1; cyc <= K + 5; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 3) begin bif.start = 1'b1; bif.a = 8'd9; end
      if (cyc == 4) bif.start = 1'b0;
      if (bif.done === 1'b1) begin dones++; r = bif.result; end
    end
    check("restart_done_count", 32'(dones), 1);
    check("restart_result", 32'(r), 6);

    // start held through the done cycle is only taken in the following IDLE cycle.
    do_conv(8'd4, 8'd13, 1'b0, r, lat);
    bif.a = 8'd7; bif.n = 8'd13; bif.mode = 1'b0; bif.start = 1'b1;
    @(negedge clk);
    check("final_start_ignored", 32'(bif.busy), 0);
    @(negedge clk);
    check("idle_start_taken", 32'(bif.busy), 1);
    bif.start = 1'b0;
    wait_done(r, lat);
    check("after_final_start", 32'(r), 11);

    // Reset in RUN aborts without done.
    @(negedge clk);
    bif.a = 8'd5; bif.n = 8'd13; bif.mode = 1'b0; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(bif.busy), 0);
    check("abort_result", 32'(bif.result), 0);
    dones = 0;
    for (int cyc = 0; cyc < K + 2; cyc++) begin
      if (bif.done === 1'b1) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(dones), 0);
    do_conv(8'd5, 8'd13, 1'b0, r, lat);
    check("after_abort", 32'(r), 6);

`ifdef MONT_DOMAIN_CONV_CHECK_EN
    do_conv(8'd5, 8'd12, 1'b0, r, lat);
    check("err_latency", 32'(lat), 1);
    check("err_flag", 32'(bif.err), 1);
    check("err_result_held", 32'(r), 6);
    do_conv(8'd3, 8'd13, 1'b0, r, lat);
    check("err_cleared", 32'(bif.err), 0);
    check("post_err_result", 32'(r), 1);
`endif

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 79) != 0);
      bif.start = ($urandom_range(0, 3) == 0);
      bif.mode = 1'($urandom_range(0, 1));
      bif.n = 8'($urandom_range(1, 127) * 2 + 1);
      bif.a = 8'($urandom_range(0, int'(bif.n) - 1));
`ifdef MONT_DOMAIN_CONV_CHECK_EN
      if ($urandom_range(0, 7) == 0) begin
        bif.n = 8'($urandom_range(0, 255));
        bif.a = 8'($urandom_range(0, 255));
      end
`endif
    end
    rst_n = 1'b1;
    bif.start = 1'b0;
    repeat (K + 3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
